// File: rtl/button_conditioner.sv
// Nine-button front end: 2-flop sync, per-bit debounce, then a one-hot
// press arbiter that emits one fixed-width pulse per accepted press.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] btn_raw,
  input  logic       enable,
  output logic [8:0] press_out,
  output logic       busy,
  output logic       multi_err,
  output logic [8:0] stable_dbg
);

  localparam int unsigned NBTN = 9;
  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW   = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PL_LAST = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  logic [8:0]    pressed;
  logic [8:0]    sync1_q, sync2_q;
  logic [8:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [NBTN];
  logic [CW-1:0] cnt_d [NBTN];

  state_e        state_q, state_d;
  logic [8:0]    sel_q, sel_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          single_hot;

  assign pressed = RAW_ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pressed;
      sync2_q <= sync1_q;
    end
  end

  // Any cycle where the synchronised input agrees with stable restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < NBTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign single_hot = (stable_q & (stable_q - 9'd1)) == '0;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pcnt_d    = pcnt_q;
    multi_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stable_q != '0) begin
          if (!enable) begin
            state_d = WAIT_REL;
          end else if (single_hot) begin
            sel_d   = stable_q;
            pcnt_d  = '0;
            state_d = PULSE;
          end else begin
            multi_err = 1'b1;
            state_d   = WAIT_REL;
          end
        end
      end
      PULSE: begin
        if (pcnt_q == PL_LAST) begin
          state_d = WAIT_REL;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      WAIT_REL: begin
        if (stable_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign press_out  = (state_q == PULSE) ? sel_q : '0;
  assign busy       = (state_q != IDLE);
  assign stable_dbg = stable_q;

endmodule
